// File: rtl/i2c_master.sv
// i2c_master: single-master sub-addressed I2C register access engine.
// 7-bit addressing, write or read of 1..255 bytes, no clock stretching.
`timescale 1ns/1ps
module i2c_master #(
    parameter int CLK_DIV = 125
) (
    input  logic       clk_50,
    input  logic       reset_n,
    input  logic       WR,
    input  logic [7:0] length,
    input  logic       request,
    output logic       DE,
    inout  wire        SDA,
    inout  wire        SCL,
    input  logic [7:0] txReg,
    output logic [7:0] rxReg,
    input  logic [6:0] address,
    input  logic [7:0] sub_address,
    output logic       busy,
    output logic [3:0] scl_ticks,
    output logic [1:0] State,
    output logic [1:0] subState
);
    localparam int CW = $clog2(CLK_DIV + 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_XFER, S_STOP} state_t;
    typedef enum logic [1:0] {B_ADDR_W, B_SUB, B_ADDR_R, B_DATA} byte_t;

    state_t        state_q;
    byte_t         byte_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    phase_q;
    logic [3:0]    tick_q;
    logic [7:0]    shift_q;
    logic [7:0]    len_q;
    logic [7:0]    sub_q;
    logic [7:0]    rx_q;
    logic [6:0]    addr_q;
    logic          wr_q;
    logic          smp_q;
    logic          sda_oe_q;
    logic          scl_oe_q;
    logic          busy_q;
    logic          de_q;

    logic       qtick;
    logic       wdir;
    logic       last;
    logic       ld_tx;
    logic [7:0] addr_byte;

    assign qtick     = (cnt_q == CW'(CLK_DIV - 1));
    assign wdir      = (byte_q != B_DATA) || wr_q;
    assign last      = (len_q == 8'd1);
    assign addr_byte = {addr_q, byte_q == B_ADDR_R};
    // write data is fetched one cycle into q0 so a txReg update made on DE lands
    assign ld_tx = (state_q == S_XFER) && (byte_q == B_DATA) && wr_q &&
                   (phase_q == 2'd0) && (tick_q == 4'd0) && (cnt_q == '0);

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            byte_q   <= B_ADDR_W;
            cnt_q    <= '0;
            phase_q  <= 2'd0;
            tick_q   <= 4'd0;
            shift_q  <= 8'h00;
            len_q    <= 8'h00;
            sub_q    <= 8'h00;
            rx_q     <= 8'h00;
            addr_q   <= 7'h00;
            wr_q     <= 1'b0;
            smp_q    <= 1'b1;
            sda_oe_q <= 1'b0;
            scl_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            de_q     <= 1'b0;
        end else begin
            de_q  <= 1'b0;
            cnt_q <= (state_q == S_IDLE || qtick) ? '0 : cnt_q + CW'(1);
            if (state_q == S_IDLE) begin
                if (request) begin
                    wr_q    <= WR;
                    len_q   <= (!WR && length == 8'd0) ? 8'd1 : length;
                    addr_q  <= address;
                    sub_q   <= sub_address;
                    byte_q  <= B_ADDR_W;
                    busy_q  <= 1'b1;
                    state_q <= S_START;
                    phase_q <= 2'd0;
                    tick_q  <= 4'd0;
                end
            end else if (qtick) begin
                phase_q <= phase_q + 2'd1;
                unique case (state_q)
                    S_START: begin
                        if (phase_q == 2'd0) begin
                            scl_oe_q <= 1'b0;
                        end else if (phase_q == 2'd1) begin
                            sda_oe_q <= 1'b1;
                        end else if (phase_q == 2'd2) begin
                            scl_oe_q <= 1'b1;
                        end else begin
                            state_q  <= S_XFER;
                            tick_q   <= 4'd0;
                            shift_q  <= addr_byte;
                            sda_oe_q <= ~addr_byte[7];
                        end
                    end
                    S_XFER: begin
                        if (phase_q == 2'd0) begin
                            scl_oe_q <= 1'b0;
                        end else if (phase_q == 2'd2) begin
                            smp_q    <= SDA;
                            scl_oe_q <= 1'b1;
                        end else if (phase_q == 2'd3) begin
                            if (tick_q != 4'd8) begin
                                tick_q  <= tick_q + 4'd1;
                                shift_q <= {shift_q[6:0], smp_q};
                                if (tick_q != 4'd7) begin
                                    sda_oe_q <= wdir & ~shift_q[6];
                                end else begin
                                    // ack slot: master ACKs read bytes except the last
                                    sda_oe_q <= ~wdir & ~last;
                                    if (!wdir) begin
                                        rx_q <= {shift_q[6:0], smp_q};
                                        de_q <= 1'b1;
                                    end
                                end
                            end else begin
                                tick_q <= 4'd0;
                                if (wdir && smp_q) begin
                                    state_q  <= S_STOP;
                                    sda_oe_q <= 1'b1;
                                end else begin
                                    unique case (byte_q)
                                        B_ADDR_W: begin
                                            byte_q   <= B_SUB;
                                            shift_q  <= sub_q;
                                            sda_oe_q <= ~sub_q[7];
                                        end
                                        B_SUB: begin
                                            if (!wr_q) begin
                                                state_q  <= S_START;
                                                byte_q   <= B_ADDR_R;
                                                sda_oe_q <= 1'b0;
                                            end else if (len_q == 8'd0) begin
                                                state_q  <= S_STOP;
                                                sda_oe_q <= 1'b1;
                                            end else begin
                                                byte_q   <= B_DATA;
                                                sda_oe_q <= 1'b0;
                                            end
                                        end
                                        B_ADDR_R: begin
                                            byte_q   <= B_DATA;
                                            sda_oe_q <= 1'b0;
                                        end
                                        default: begin
                                            de_q <= wr_q;
                                            if (last) begin
                                                state_q  <= S_STOP;
                                                sda_oe_q <= 1'b1;
                                            end else begin
                                                len_q    <= len_q - 8'd1;
                                                sda_oe_q <= 1'b0;
                                            end
                                        end
                                    endcase
                                end
                            end
                        end
                    end
                    S_STOP: begin
                        if (phase_q == 2'd0) begin
                            scl_oe_q <= 1'b0;
                        end else if (phase_q == 2'd1) begin
                            sda_oe_q <= 1'b0;
                        end else if (phase_q == 2'd3) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end else if (ld_tx) begin
                shift_q  <= txReg;
                sda_oe_q <= ~txReg[7];
            end
        end
    end

    assign SDA       = sda_oe_q ? 1'b0 : 1'bz;
    assign SCL       = scl_oe_q ? 1'b0 : 1'bz;
    assign DE        = de_q;
    assign rxReg     = rx_q;
    assign busy      = busy_q;
    assign scl_ticks = tick_q;
    assign State     = state_q;
    assign subState  = phase_q;
endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: directed bench with an I2C slave model and bus-event scoreboard.
`timescale 1ns/1ps
module tb_i2c_master;
  localparam int DIV = 4;
  localparam int IT_S = 'h1000;
  localparam int IT_P = 'h2000;

  logic       clk_50 = 1'b0;
  logic       reset_n = 1'b0;
  logic       WR = 1'b0;
  logic [7:0] length = 8'h00;
  logic       request = 1'b0;
  logic [7:0] txReg = 8'h00;
  logic [6:0] address = 7'h00;
  logic [7:0] sub_address = 8'h00;
  logic       DE;
  logic [7:0] rxReg;
  logic       busy;
  logic [3:0] scl_ticks;
  logic [1:0] State;
  logic [1:0] subState;
  wire        SDA;
  wire        SCL;

  pullup (SDA);
  pullup (SCL);

  logic       sl_drv = 1'b0;
  logic       ack_en = 1'b1;
  logic [7:0] rd_byte = 8'hA5;
  assign SDA = sl_drv ? 1'b0 : 1'bz;

  i2c_master #(.CLK_DIV(DIV)) dut (
    .clk_50(clk_50), .reset_n(reset_n), .WR(WR), .length(length),
    .request(request), .DE(DE), .SDA(SDA), .SCL(SCL), .txReg(txReg),
    .rxReg(rxReg), .address(address), .sub_address(sub_address),
    .busy(busy), .scl_ticks(scl_ticks), .State(State), .subState(subState)
  );

  always #10 clk_50 = ~clk_50;

  int         obs [64];
  int         obs_n = 0;
  logic       sda_p = 1'b1, scl_p = 1'b1, sda_c, scl_c, ackb = 1'b0;
  logic       hi = 1'b0, rd_mode = 1'b0;
  logic [7:0] shr = 8'h00;
  int         bcnt = 0, bnum = 0;

  // slave model and bus monitor, sampled away from the DUT's clock edge
  always @(negedge clk_50) begin
    sda_c = (SDA !== 1'b0);
    scl_c = (SCL !== 1'b0);
    if (!reset_n) begin
      sl_drv = 1'b0; bcnt = 0; bnum = 0; rd_mode = 1'b0; hi = 1'b0;
    end else if (scl_p && scl_c && sda_p && !sda_c) begin
      if (obs_n < 64) obs[obs_n] = IT_S;
      obs_n++;
      bcnt = 0; bnum = 0; rd_mode = 1'b0; hi = 1'b0; sl_drv = 1'b0;
    end else if (scl_p && scl_c && !sda_p && sda_c) begin
      if (obs_n < 64) obs[obs_n] = IT_P;
      obs_n++;
      sl_drv = 1'b0; hi = 1'b0;
    end else if (!scl_p && scl_c) begin
      hi = 1'b1;
      if (bcnt < 8) shr = {shr[6:0], sda_c};
      else ackb = sda_c;
    end else if (scl_p && !scl_c && hi) begin
      hi = 1'b0;
      if (bcnt == 8) begin
        if (obs_n < 64) obs[obs_n] = {23'd0, ackb, shr};
        obs_n++;
        bcnt = 0;
        bnum++;
        sl_drv = (rd_mode && !ackb) ? ~rd_byte[7] : 1'b0;
      end else begin
        bcnt++;
        if (bcnt == 8) begin
          if (bnum == 0) rd_mode = shr[0];
          sl_drv = (rd_mode && bnum >= 1) ? 1'b0 : ack_en;
        end else begin
          sl_drv = (rd_mode && bnum >= 1) ? ~rd_byte[7-bcnt] : 1'b0;
        end
      end
    end
    sda_p = sda_c;
    scl_p = scl_c;
  end

  int de_cnt = 0;
  int busy_cyc = 0;
  always @(negedge clk_50) begin
    if (DE) de_cnt++;
    if (busy) busy_cyc++;
  end

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int obs_rd = 0;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic drain(input string tag);
    int e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(tag, (obs_rd < obs_n && obs_rd < 64) ? obs[obs_rd] : -1, e);
      obs_rd++;
    end
    chk({tag, "_count"}, obs_n, obs_rd);
  endtask

  task automatic start_txn(input logic wr, input logic [7:0] len,
                           input logic [6:0] a, input logic [7:0] s);
    @(negedge clk_50);
    WR = wr; length = len; address = a; sub_address = s; request = 1'b1;
    @(negedge clk_50);
    request = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 4000 && busy; i++) @(negedge clk_50);
    chk(tag, busy, 1'b0);
  endtask

  task automatic wait_de(input string tag);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_50);
      if (DE) break;
    end
    chk(tag, DE, 1'b1);
  endtask

  int b0, d0;

  initial begin
    repeat (3) @(negedge clk_50);
    chk("rst_sda", SDA, 1'b1);
    chk("rst_scl", SCL, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_de", DE, 1'b0);
    chk("rst_rx", rxReg, 8'h00);
    chk("rst_state", State, 2'd0);
    chk("rst_sub", subState, 2'd0);
    chk("rst_ticks", scl_ticks, 4'd0);
    reset_n = 1'b1;
    @(negedge clk_50);

    // single-byte write
    txReg = 8'h80;
    exp_q = '{IT_S, 'h098, 'h0FF, 'h080, IT_P};
    b0 = busy_cyc; d0 = de_cnt;
    start_txn(1'b1, 8'd1, 7'h4C, 8'hFF);
    chk("wr1_busy", busy, 1'b1);
    chk("wr1_state", State, 2'd1);
    wait_idle("wr1_idle");
    chk("wr1_busylen", (busy_cyc - b0 >= 448) && (busy_cyc - b0 <= 496), 1'b1);
    chk("wr1_de", de_cnt - d0, 1);
    drain("wr1_bus");

    // single-byte read, master NACKs the only byte
    exp_q = '{IT_S, 'h098, 'h011, IT_S, 'h099, 'h1A5, IT_P};
    d0 = de_cnt;
    start_txn(1'b0, 8'd1, 7'h4C, 8'h11);
    wait_de("rd1_de_seen");
    chk("rd1_rx_at_de", rxReg, 8'hA5);
    wait_idle("rd1_idle");
    chk("rd1_de", de_cnt - d0, 1);
    chk("rd1_rx", rxReg, 8'hA5);
    drain("rd1_bus");

    // three-byte write, host supplies next byte on each DE
    txReg = 8'h01;
    exp_q = '{IT_S, 'h098, 'h020, 'h001, 'h002, 'h003, IT_P};
    d0 = de_cnt;
    start_txn(1'b1, 8'd3, 7'h4C, 8'h20);
    wait_de("wr3_de1");
    txReg = 8'h02;
    wait_de("wr3_de2");
    txReg = 8'h03;
    wait_idle("wr3_idle");
    chk("wr3_de", de_cnt - d0, 3);
    drain("wr3_bus");

    // address NACK with request held high, then length-0 write accepted
    ack_en = 1'b0;
    exp_q = '{IT_S, 'h198, IT_P};
    d0 = de_cnt;
    @(negedge clk_50);
    WR = 1'b1; length = 8'd0; address = 7'h4C; sub_address = 8'h05;
    request = 1'b1;
    @(negedge clk_50);
    chk("nack_busy", busy, 1'b1);
    wait_idle("nack_idle");
    ack_en = 1'b1;
    drain("nack_bus");
    @(negedge clk_50);
    chk("held_accept", busy, 1'b1);
    request = 1'b0;
    exp_q = '{IT_S, 'h098, 'h005, IT_P};
    wait_idle("len0_idle");
    chk("nack_len0_de", de_cnt - d0, 0);
    drain("len0_bus");

    // reset asserted mid-byte while SCL is high and SDA is pulled low
    start_txn(1'b1, 8'd1, 7'h4C, 8'h33);
    for (int i = 0; i < 2000; i++) begin
      if (State == 2'd2 && scl_ticks == 4'd1 && subState == 2'd2) break;
      @(negedge clk_50);
    end
    chk("mid_reach", (State == 2'd2 && scl_ticks == 4'd1), 1'b1);
    chk("mid_sda_low", SDA, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("mid_sda", SDA, 1'b1);
    chk("mid_scl", SCL, 1'b1);
    chk("mid_state", State, 2'd0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_rx", rxReg, 8'h00);
    chk("mid_ticks", scl_ticks, 4'd0);
    repeat (4) @(negedge clk_50);
    reset_n = 1'b1;
    repeat (4) @(negedge clk_50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
